// File: rtl/sequence_generator_moore_if.sv
// Bus bundle for sequence_generator_moore: transmission request fields in,
// registered serial stream and status out.
interface sequence_generator_moore_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP_W = 2
);
  localparam int unsigned LEN_W = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, repeat_cnt, gap,
    input  serial_out, busy, done
  );

  modport slave (
    input  start, pattern, len, repeat_cnt, gap,
    output serial_out, busy, done
  );
endinterface

// File: rtl/sequence_generator_moore.sv
// Moore serial pattern generator: shifts a captured pattern MSB-first from
// bit len, repeated repeat_cnt+1 times with gap forced-0 cycles in between.
module sequence_generator_moore #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP_W = 2
) (
  input logic                    clk,
  input logic                    reset,
  sequence_generator_moore_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State, captured fields, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      bit_q    <= '0;
      gcnt_q   <= '0;
      serial_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
      bit_q    <= bit_d;
      gcnt_q   <= gcnt_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state; counters are tested for zero before decrementing so they never wrap.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d   = bus.pattern;
          len_d   = bus.len;
          rep_d   = bus.repeat_cnt;
          gap_d   = bus.gap;
          bit_d   = bus.len;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_q != '0) begin
          bit_d = bit_q - LEN_W'(1);
        end else if (rep_q != '0) begin
          rep_d = rep_q - REP_W'(1);
          if (gap_q != '0) begin
            gcnt_d  = gap_q - GAP_W'(1);
            state_d = GAP;
          end else begin
            bit_d = len_q;
          end
        end else begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (gcnt_q == '0) begin
          bit_d   = len_q;
          state_d = SHIFT;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values are a function of the upcoming state only, then registered.
  always_comb begin
    serial_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_d)
      SHIFT: begin
        serial_d = pat_d[bit_d];
        busy_d   = 1'b1;
      end
      GAP:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.serial_out = serial_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_sequence_generator_moore.sv
// Directed bench for sequence_generator_moore: cycle-by-cycle comparison of
// {serial_out, busy, done} against hand-computed streams.
module tb_sequence_generator_moore;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sequence_generator_moore_if #(.WIDTH(8), .REP_W(4), .GAP_W(2)) bus_if ();

  sequence_generator_moore #(.WIDTH(8), .REP_W(4), .GAP_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: {serial,busy,done} got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [7:0] p, input logic [2:0] l,
                         input logic [3:0] r, input logic [1:0] g);
    bus_if.pattern    = p;
    bus_if.len        = l;
    bus_if.repeat_cnt = r;
    bus_if.gap        = g;
  endtask

  // Expected vectors are written first-cycle-leftmost in the low n bits.
  task automatic run(input string tag, input int n, input logic [63:0] es,
                     input logic [63:0] eb, input logic [63:0] ed,
                     input bit pulse, input bit scramble);
    for (int i = 0; i < n; i++) begin
      tick();
      if (pulse && i == 0) bus_if.start = 1'b0;
      if (scramble && i == 1) set_cfg(8'hFF, 3'd1, 4'd0, 2'd3);
      check($sformatf("%s[%0d]", tag, i),
            {bus_if.serial_out, bus_if.busy, bus_if.done},
            {es[n-1-i], eb[n-1-i], ed[n-1-i]});
    end
  endtask

  initial begin
    int busy_cycles;
    int done_cnt;
    int busy_edges;
    logic prev_busy;

    reset        = 1'b1;
    bus_if.start = 1'b0;
    set_cfg(8'h00, 3'd0, 4'd0, 2'd0);
    tick();
    tick();
    check("reset", {bus_if.serial_out, bus_if.busy, bus_if.done}, 3'b000);

    // start together with reset: reset wins
    bus_if.start = 1'b1;
    set_cfg(8'h07, 3'd2, 4'd0, 2'd0);
    tick();
    check("reset_prio", {bus_if.serial_out, bus_if.busy, bus_if.done}, 3'b000);
    bus_if.start = 1'b0;
    reset        = 1'b0;
    tick();
    check("idle", {bus_if.serial_out, bus_if.busy, bus_if.done}, 3'b000);

    // single 3-bit burst
    bus_if.start = 1'b1;
    run("p07", 5, 64'b11100, 64'b11100, 64'b00010, 1'b1, 1'b0);

    // three repetitions with one gap bit
    set_cfg(8'h0D, 3'd3, 4'd2, 2'd1);
    bus_if.start = 1'b1;
    run("p0d", 16, 64'hD6B4, 64'hFFFC, 64'h0002, 1'b1, 1'b0);

    // full width, gap ignored after the only repetition
    set_cfg(8'hA5, 3'd7, 4'd0, 2'd3);
    bus_if.start = 1'b1;
    run("pa5", 10, 64'b1010010100, 64'b1111111100, 64'b0000000010, 1'b1, 1'b0);

    // inputs changed while busy must not disturb the stream
    set_cfg(8'h0D, 3'd3, 4'd2, 2'd1);
    bus_if.start = 1'b1;
    run("scramble", 16, 64'hD6B4, 64'hFFFC, 64'h0002, 1'b1, 1'b1);

    // start held high: bursts separated by DONE and IDLE cycles
    set_cfg(8'h07, 3'd2, 4'd0, 2'd0);
    bus_if.start = 1'b1;
    run("held", 10, 64'b1110011100, 64'b1110011100, 64'b0001000010, 1'b0, 1'b0);
    bus_if.start = 1'b0;
    tick();
    check("held_stop", {bus_if.serial_out, bus_if.busy, bus_if.done}, 3'b000);

    // abort on the third SHIFT cycle, then start on the first edge after reset
    set_cfg(8'h0D, 3'd3, 4'd2, 2'd1);
    bus_if.start = 1'b1;
    run("abort", 3, 64'b110, 64'b111, 64'b000, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    check("abort_rst", {bus_if.serial_out, bus_if.busy, bus_if.done}, 3'b000);
    reset        = 1'b0;
    bus_if.start = 1'b1;
    run("replay", 16, 64'hD6B4, 64'hFFFC, 64'h0002, 1'b1, 1'b0);

    // reset during a gap cycle
    set_cfg(8'h03, 3'd1, 4'd1, 2'd3);
    bus_if.start = 1'b1;
    run("gap_abort", 4, 64'b1100, 64'b1111, 64'b0000, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("gap_rst", {bus_if.serial_out, bus_if.busy, bus_if.done}, 3'b000);
    tick();
    check("gap_rst_idle", {bus_if.serial_out, bus_if.busy, bus_if.done}, 3'b000);

    // maximum len, repeat_cnt and gap: 16*8 + 15*3 = 173 busy cycles
    set_cfg(8'hFF, 3'd7, 4'd15, 2'd3);
    bus_if.start = 1'b1;
    busy_cycles  = 0;
    done_cnt     = 0;
    busy_edges   = 0;
    prev_busy    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      bus_if.start = 1'b0;
      if (bus_if.busy) busy_cycles++;
      if (bus_if.busy && !prev_busy) busy_edges++;
      if (bus_if.done) done_cnt++;
      prev_busy = bus_if.busy;
      if (done_cnt != 0 && !bus_if.done) break;
    end
    check_int("max_busy_cycles", busy_cycles, 173);
    check_int("max_busy_runs", busy_edges, 1);
    check_int("max_done_pulses", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sequence_generator_moore.md
SEQUENCE_GENERATOR_MOORE -- requirements
Module: sequence_generator_moore

Interface
REQ-001 Parameter WIDTH, default 8: maximum pattern length in bits, at least 2.
REQ-002 Parameter REP_W, default 4: width of the repeat-count field.
REQ-003 Parameter GAP_W, default 2: width of the inter-repetition gap field.
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port reset, input, 1: reset is synchronous and active-high.
REQ-006 Port start, input, 1: request to begin a transmission, sampled only in IDLE.
REQ-007 Port pattern, input, WIDTH: bit pattern to transmit, MSB-first from bit len.
REQ-008 Port len, input, $clog2(WIDTH): pattern length minus one, giving 1..WIDTH bits.
REQ-009 Port repeat_cnt, input, REP_W: number of repetitions minus one, giving 1..2^REP_W.
REQ-010 Port gap, input, GAP_W: number of forced-0 bit cycles between repetitions, 0..2^GAP_W-1.
REQ-011 Port serial_out, output, 1: registered serial bit stream, one bit per clock.
REQ-012 Port busy, output, 1: high while pattern or gap bits are being driven.
REQ-013 Port done, output, 1: one-cycle pulse after the final pattern bit.

Function
REQ-014 The block SHALL be a Moore FSM with states IDLE, SHIFT, GAP and DONE, and all outputs SHALL be registered and depend on state only.
REQ-015 In IDLE, with start=1 at an edge, the block SHALL capture pattern, len, repeat_cnt and gap, then enter SHIFT with serial_out=pattern[len] and busy=1 after that edge.
REQ-016 In SHIFT, each edge SHALL advance one bit: pattern[len], pattern[len-1], down to pattern[0].
REQ-017 After bit 0 is driven, if repetitions remain and the captured gap is nonzero, the block SHALL enter GAP for exactly gap cycles with serial_out=0 and busy=1.
REQ-018 After bit 0 is driven, if repetitions remain and the captured gap is 0, the block SHALL restart at pattern[len] on the next cycle with no idle bit.
REQ-019 After GAP, the block SHALL return to SHIFT starting at pattern[len].
REQ-020 After bit 0 of the last repetition, the block SHALL enter DONE for one cycle with done=1, busy=0 and serial_out=0, then return to IDLE.
REQ-021 No gap cycles SHALL be inserted after the final repetition.
REQ-022 busy SHALL stay high for exactly (repeat_cnt+1)*(len+1) + repeat_cnt*gap consecutive cycles.
REQ-023 start SHALL be ignored in SHIFT, GAP and DONE.
REQ-024 If start is held high, the next transmission SHALL begin one cycle after IDLE is re-entered, giving 2 cycles of serial_out=0 between streams.
REQ-025 Changes on pattern, len, repeat_cnt or gap while busy SHALL NOT affect the stream in progress.
REQ-026 In IDLE, serial_out, busy and done SHALL all be 0.
REQ-027 The bit and repetition counters SHALL NOT wrap: len=WIDTH-1 and the maximum repeat_cnt and gap SHALL operate exactly per REQ-022.

Reset
REQ-028 With reset=1 at an edge, the block SHALL enter IDLE with serial_out=0, busy=0, done=0 and all counters and captured fields cleared.
REQ-029 Reset SHALL take priority over start and over any state, including mid-SHIFT and mid-GAP.
REQ-030 A transmission aborted by reset SHALL NOT produce a done pulse.
REQ-031 A start presented on the first edge after reset deasserts SHALL be accepted normally.

Verification
REQ-032 Scenario: pattern=8'h07, len=2, repeat_cnt=0, gap=0, start pulse -> serial_out 1,1,1; busy high for 3 cycles; done on the 4th cycle; then IDLE.
REQ-033 Scenario: pattern=8'h0D, len=3, repeat_cnt=2, gap=1 -> serial_out 1101 0 1101 0 1101; busy high for 14 cycles; exactly one done pulse.
REQ-034 Scenario: pattern=8'hA5, len=7, repeat_cnt=0 -> serial_out 1,0,1,0,0,1,0,1; busy high for 8 cycles.
REQ-035 Scenario: start held high, pattern=8'h07, len=2, repeat_cnt=0 -> repeating 111 with two 0 cycles (DONE, IDLE) between bursts.
REQ-036 Scenario: reset asserted on the 3rd SHIFT cycle of the REQ-033 setup -> next cycle serial_out=0, busy=0; done never asserted; a later start replays the full stream.
REQ-037 Scenario: pattern changed from 8'h0D to 8'hFF during busy in the REQ-033 setup -> output stream unchanged from REQ-033.
